// File: rtl/rob_commit_unit_pkg.sv
// Shared sizing constants for the reorder/commit engine.
// Default RRF/ROB depth, tag width, architectural register width and data width.
// Constants only: no logic, no latency, no flow control.
package rob_commit_unit_pkg;
    localparam int RRF_NUM  = 64;
    localparam int RRF_SEL  = 6;
    localparam int REG_SEL  = 5;
    localparam int DATA_LEN = 32;
endpackage

// File: rtl/rob_commit_unit_entry_status.sv
// Per-entry valid/finished bits with dispatch > commit-clear > finish-set priority.
// Latency: updates land on the rising edge and are visible the following cycle.
// Backpressure: none; every request is applied in the cycle it is presented.
module rob_entry_status
    import rob_commit_unit_pkg::*;
#(
    parameter int P_RRF_NUM = RRF_NUM,
    parameter int P_RRF_SEL = RRF_SEL
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 i_dp_en,
    input  logic [P_RRF_SEL-1:0] i_dp_tag,
    input  logic                 i_com_en,
    input  logic [P_RRF_SEL-1:0] i_com_tag,
    input  logic                 i_fin_en,
    input  logic [P_RRF_SEL-1:0] i_fin_tag,
    output logic [P_RRF_NUM-1:0] o_valid,
    output logic [P_RRF_NUM-1:0] o_finished
);
    logic [P_RRF_NUM-1:0] r_valid;
    logic [P_RRF_NUM-1:0] r_finished;

    // A finish is only honoured by an entry that is already live.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid    <= '0;
            r_finished <= '0;
        end else begin
            for (int i = 0; i < P_RRF_NUM; i++) begin
                if (i_dp_en && (i_dp_tag == P_RRF_SEL'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_finished[i] <= 1'b0;
                end else if (i_com_en && (i_com_tag == P_RRF_SEL'(i))) begin
                    r_valid[i]    <= 1'b0;
                    r_finished[i] <= 1'b0;
                end else if (i_fin_en && (i_fin_tag == P_RRF_SEL'(i)) && r_valid[i]) begin
                    r_finished[i] <= 1'b1;
                end
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_finished = r_finished;
endmodule

// File: rtl/rob_commit_unit.sv
// In-order retire engine: one commit per cycle once the head entry is finished.
// Latency: commit outputs are combinational from registered state (finish at N, ARF writes at N+1).
// Backpressure: none; dispatch is never stalled, the allocator tracks occupancy via com_inst_num_o.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int P_RRF_NUM = RRF_NUM,
    parameter int P_RRF_SEL = RRF_SEL,
    parameter int P_REG_SEL = REG_SEL
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 dp_en_i,
    input  logic [P_RRF_SEL-1:0] dp_rrftag_i,
    input  logic [P_REG_SEL-1:0] dp_dst_num_i,
    input  logic                 dp_dst_en_i,
    input  logic                 finish_we_i,
    input  logic [P_RRF_SEL-1:0] finish_rrftag_i,
    output logic [1:0]           com_inst_num_o,
    output logic                 completed_we_o,
    output logic [P_REG_SEL-1:0] completed_dstnum_o,
    output logic [P_RRF_SEL-1:0] completed_dst_rrftag_o,
    output logic [P_RRF_SEL-1:0] comptr_o,
    output logic                 rob_empty_o
);
    logic [P_RRF_SEL-1:0] r_comptr;
    logic [P_REG_SEL-1:0] r_dst_num [P_RRF_NUM];
    logic                 r_dst_en  [P_RRF_NUM];
    logic [P_RRF_NUM-1:0] w_valid;
    logic [P_RRF_NUM-1:0] w_finished;
    logic                 w_commit;

    rob_entry_status #(
        .P_RRF_NUM (P_RRF_NUM),
        .P_RRF_SEL (P_RRF_SEL)
    ) u_status (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .i_dp_en    (dp_en_i),
        .i_dp_tag   (dp_rrftag_i),
        .i_com_en   (w_commit),
        .i_com_tag  (r_comptr),
        .i_fin_en   (finish_we_i),
        .i_fin_tag  (finish_rrftag_i),
        .o_valid    (w_valid),
        .o_finished (w_finished)
    );

    assign w_commit = w_valid[r_comptr] & w_finished[r_comptr];

    // Destination payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (dp_en_i) begin
            r_dst_num[dp_rrftag_i] <= dp_dst_num_i;
            r_dst_en[dp_rrftag_i]  <= dp_dst_en_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_comptr <= '0;
        end else if (w_commit) begin
            r_comptr <= r_comptr + P_RRF_SEL'(1);
        end
    end

    assign com_inst_num_o         = {1'b0, w_commit};
    assign completed_we_o         = w_commit & r_dst_en[r_comptr];
    assign completed_dstnum_o     = w_commit ? r_dst_num[r_comptr] : '0;
    assign completed_dst_rrftag_o = r_comptr;
    assign comptr_o               = r_comptr;
    assign rob_empty_o            = ~|w_valid;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed vector table, hand sequences, randomized model run.
module tb_rob_commit_unit;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       dp_en_i = 1'b0;
    logic [5:0] dp_rrftag_i = '0;
    logic [4:0] dp_dst_num_i = '0;
    logic       dp_dst_en_i = 1'b0;
    logic       finish_we_i = 1'b0;
    logic [5:0] finish_rrftag_i = '0;
    logic [1:0] com_inst_num_o;
    logic       completed_we_o;
    logic [4:0] completed_dstnum_o;
    logic [5:0] completed_dst_rrftag_o;
    logic [5:0] comptr_o;
    logic       rob_empty_o;

    int n_checks = 0;
    int n_errors = 0;

    rob_commit_unit dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .dp_en_i                (dp_en_i),
        .dp_rrftag_i            (dp_rrftag_i),
        .dp_dst_num_i           (dp_dst_num_i),
        .dp_dst_en_i            (dp_dst_en_i),
        .finish_we_i            (finish_we_i),
        .finish_rrftag_i        (finish_rrftag_i),
        .com_inst_num_o         (com_inst_num_o),
        .completed_we_o         (completed_we_o),
        .completed_dstnum_o     (completed_dstnum_o),
        .completed_dst_rrftag_o (completed_dst_rrftag_o),
        .comptr_o               (comptr_o),
        .rob_empty_o            (rob_empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       dp_en;
        logic [5:0] dp_tag;
        logic [4:0] dp_dst;
        logic       dp_den;
        logic       fin_we;
        logic [5:0] fin_tag;
        logic       e_com;
        logic       e_we;
        logic [4:0] e_dn;
        logic [5:0] e_tag;
        logic [5:0] e_ptr;
        logic       e_empty;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the ROB as a table of in-flight instructions plus a head index.
    bit       m_valid [64];
    bit       m_fin   [64];
    bit [4:0] m_dst   [64];
    bit       m_den   [64];
    int       m_head;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string nm, input bit com, input bit we, input int dn,
                            input int tag, input int ptr, input bit empty);
        chk({nm, ".com_inst_num"}, int'(com_inst_num_o), int'(com));
        chk({nm, ".completed_we"}, int'(completed_we_o), int'(we));
        chk({nm, ".completed_dstnum"}, int'(completed_dstnum_o), dn);
        chk({nm, ".completed_rrftag"}, int'(completed_dst_rrftag_o), tag);
        chk({nm, ".comptr"}, int'(comptr_o), ptr);
        chk({nm, ".rob_empty"}, int'(rob_empty_o), int'(empty));
    endtask

    // Drive one cycle of inputs, take the edge, settle just after it.
    task automatic cycle(input bit dpe, input int tag, input int dst, input bit den,
                         input bit fwe, input int ftag);
        dp_en_i         = dpe;
        dp_rrftag_i     = 6'(tag);
        dp_dst_num_i    = 5'(dst);
        dp_dst_en_i     = den;
        finish_we_i     = fwe;
        finish_rrftag_i = 6'(ftag);
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input bit dpe, input int tag, input int dst, input bit den,
                                input bit fwe, input int ftag, input bit com, input bit we,
                                input int dn, input int etag, input int ptr, input bit empty);
        vec_t v;
        v.dp_en = dpe; v.dp_tag = 6'(tag); v.dp_dst = 5'(dst); v.dp_den = den;
        v.fin_we = fwe; v.fin_tag = 6'(ftag);
        v.e_com = com; v.e_we = we; v.e_dn = 5'(dn); v.e_tag = 6'(etag);
        v.e_ptr = 6'(ptr); v.e_empty = empty;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_fin[i]   = 0;
        end
        m_head = 0;
    endtask

    // Apply one clock of events to the model: retire the head if done, record the
    // finish on a live instruction, then a new dispatch overwrites its slot.
    task automatic model_step(input bit dpe, input int tag, input int dst, input bit den,
                              input bit fwe, input int ftag);
        bit retire;
        bit live;
        int old_head;
        old_head = m_head;
        retire   = m_valid[m_head] && m_fin[m_head];
        live     = m_valid[ftag];
        if (retire) begin
            m_valid[old_head] = 0;
            m_fin[old_head]   = 0;
            m_head            = (m_head + 1) % 64;
        end
        if (fwe && live && !(retire && ftag == old_head))
            m_fin[ftag] = 1;
        if (dpe) begin
            m_valid[tag] = 1;
            m_fin[tag]   = 0;
            m_dst[tag]   = 5'(dst);
            m_den[tag]   = den;
        end
    endtask

    task automatic model_check(input string nm);
        bit done;
        int live_cnt;
        done     = m_valid[m_head] && m_fin[m_head];
        live_cnt = 0;
        for (int i = 0; i < 64; i++) live_cnt += int'(m_valid[i]);
        chk_outs(nm, done, done && m_den[m_head], done ? int'(m_dst[m_head]) : 0,
                 m_head, m_head, live_cnt == 0);
    endtask

    initial begin
        // Reset held: outputs must show the idle state.
        repeat (2) @(posedge clk_i);
        #1;
        chk_outs("reset_hold", 0, 0, 0, 0, 0, 1);
        reset_i = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        chk_outs("reset_release", 0, 0, 0, 0, 0, 1);

        //            dp tag dst den fw ftag | com we dn tag ptr empty
        vecs.push_back(mk(1, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0,   0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 2, 2, 1, 0, 0,   0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 3, 3, 1, 0, 0,   0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3,   0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2,   0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 2, 2, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 3, 3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 4, 1));
        vecs.push_back(mk(1, 4, 7, 0, 0, 0,   0, 0, 0, 4, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4,   1, 0, 7, 4, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 5, 5, 1));
        vecs.push_back(mk(1, 5, 9, 1, 1, 5,   0, 0, 0, 5, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 10,  0, 0, 0, 5, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5,   1, 1, 9, 5, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 6, 6, 1));
        vecs.push_back(mk(1, 6, 11, 1, 0, 0,  0, 0, 0, 6, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 6,   1, 1, 11, 6, 6, 0));
        vecs.push_back(mk(1, 6, 12, 1, 0, 0,  0, 0, 0, 7, 7, 0));

        foreach (vecs[k]) begin
            cycle(vecs[k].dp_en, vecs[k].dp_tag, vecs[k].dp_dst, vecs[k].dp_den,
                  vecs[k].fin_we, vecs[k].fin_tag);
            chk_outs($sformatf("vec%0d", k), vecs[k].e_com, vecs[k].e_we, vecs[k].e_dn,
                     vecs[k].e_tag, vecs[k].e_ptr, vecs[k].e_empty);
        end

        // Reset mid-operation with entries 6, 7, 8 live: must clear asynchronously.
        cycle(1, 7, 13, 1, 0, 0);
        cycle(1, 8, 14, 1, 0, 0);
        chk("midrst_pre.rob_empty", int'(rob_empty_o), 0);
        #2;
        reset_i = 1'b0;
        #1;
        chk_outs("midrst_async", 0, 0, 0, 0, 0, 1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        chk_outs("midrst_after", 0, 0, 0, 0, 0, 1);

        // Walk the head to 63, then retire across the wrap.
        for (int t = 0; t < 63; t++) begin
            cycle(1, t, t, 1, 0, 0);
            cycle(0, 0, 0, 0, 1, t);
            cycle(0, 0, 0, 0, 0, 0);
        end
        chk_outs("wrap_at63", 0, 0, 0, 63, 63, 1);
        cycle(1, 63, 20, 1, 0, 0);
        cycle(1, 0, 21, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 63);
        chk_outs("wrap_commit63", 1, 1, 20, 63, 63, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk_outs("wrap_commit0", 1, 1, 21, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk_outs("wrap_after", 0, 0, 0, 1, 1, 1);

        // Randomized run against the model, allocator-style in-order dispatch.
        reset_i = 1'b0;
        cycle(0, 0, 0, 0, 0, 0);
        reset_i = 1'b1;
        model_reset();
        begin
            int alloc;
            alloc = 0;
            for (int n = 0; n < 3000; n++) begin
                bit dpe, den, fwe;
                int dst, ftag;
                dpe  = ($urandom_range(0, 2) != 0) && !m_valid[alloc];
                dst  = int'($urandom_range(0, 31));
                den  = 1'($urandom_range(0, 1));
                fwe  = 1'($urandom_range(0, 1));
                ftag = ($urandom_range(0, 1) == 1) ? (m_head + int'($urandom_range(0, 7))) % 64
                                                   : int'($urandom_range(0, 63));
                cycle(dpe, alloc, dst, den, fwe, ftag);
                model_step(dpe, alloc, dst, den, fwe, ftag);
                if (dpe) alloc = (alloc + 1) % 64;
                model_check($sformatf("rand%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
